// File: rtl/div32_seq.sv
// Sequential 32-bit restoring divider, signed/unsigned, one quotient bit per cycle.
// Latency 34 cycles from start to end of done (1 cycle for divide-by-zero); start is ignored while busy.
module div32_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        sign,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] Q,
  output logic [31:0] R,
  output logic        busy,
  output logic        done,
  output logic        div_zero
);

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t      state, state_nxt;
  logic [31:0] p;
  logic [31:0] d;
  logic [31:0] dvs;
  logic [4:0]  cnt;
  logic        neg_q, neg_r;
  logic        accept, bzero;
  logic [32:0] t;
  logic [31:0] a_mag, b_mag;

  assign accept = start && ((state == IDLE) || (state == DONE));
  assign bzero  = (B == 32'd0);
  assign a_mag  = (sign && A[31]) ? -A : A;
  assign b_mag  = (sign && B[31]) ? -B : B;
  // Bit 32 of the trial difference is the borrow; when it is clear the
  // difference fits in 32 bits, so only the low word is kept as remainder.
  assign t      = {p, d[31]} - {1'b0, dvs};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = bzero ? DONE : RUN;
      RUN:     if (cnt == 5'd0) state_nxt = FIX;
      FIX:     state_nxt = DONE;
      DONE:    state_nxt = accept ? (bzero ? DONE : RUN) : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN) || (state == FIX);
    done = (state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p        <= '0;
      d        <= '0;
      dvs      <= '0;
      cnt      <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      Q        <= '0;
      R        <= '0;
      div_zero <= 1'b0;
    end else if (accept) begin
      if (bzero) begin
        Q        <= 32'hFFFF_FFFF;
        R        <= A;
        div_zero <= 1'b1;
      end else begin
        p        <= '0;
        d        <= a_mag;
        dvs      <= b_mag;
        neg_q    <= sign & (A[31] ^ B[31]);
        neg_r    <= sign & A[31];
        cnt      <= 5'd31;
        div_zero <= 1'b0;
      end
    end else if (state == RUN) begin
      p <= t[32] ? {p[30:0], d[31]} : t[31:0];
      d <= {d[30:0], ~t[32]};
      if (cnt != 5'd0) cnt <= cnt - 5'd1;
    end else if (state == FIX) begin
      Q <= neg_q ? -d : d;
      R <= neg_r ? -p : p;
    end
  end

endmodule

// File: tb/tb_div32_seq.sv
// Self-checking bench for div32_seq: cycle-level behavioural model plus directed literal cases.
module tb_div32_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        sign;
  logic [31:0] A, B;
  logic [31:0] Q, R;
  logic        busy, done, div_zero;

  int n_chk  = 0;
  int n_fail = 0;

  div32_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sign(sign), .A(A), .B(B),
    .Q(Q), .R(R), .busy(busy), .done(done), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic: 64-bit signed division truncates toward zero and
  // gives the remainder the dividend's sign; the low word handles overflow.
  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic s);
    longint sa, sb, q, r;
    sa = s ? longint'($signed(a)) : longint'(a);
    sb = s ? longint'($signed(b)) : longint'(b);
    q  = sa / sb;
    r  = sa % sb;
    return {q[31:0], r[31:0]};
  endfunction

  // Cycle model: a nonzero division occupies 33 busy cycles, then done.
  int          m_cnt;
  logic        m_done, m_dz;
  logic [31:0] m_q, m_r, pq, pr;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt <= 0; m_done <= 1'b0; m_dz <= 1'b0;
      m_q <= '0; m_r <= '0; pq <= '0; pr <= '0;
    end else if (m_cnt != 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) begin
        m_q <= pq; m_r <= pr; m_done <= 1'b1;
      end else begin
        m_done <= 1'b0;
      end
    end else if (start) begin
      if (B == 32'd0) begin
        m_q <= 32'hFFFF_FFFF; m_r <= A; m_dz <= 1'b1; m_done <= 1'b1;
      end else begin
        {pq, pr} <= ref_div(A, B, sign);
        m_cnt <= 33; m_dz <= 1'b0; m_done <= 1'b0;
      end
    end else begin
      m_done <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("busy", {31'd0, busy}, {31'd0, m_cnt != 0});
      chk("done", {31'd0, done}, {31'd0, m_done});
      chk("div_zero", {31'd0, div_zero}, {31'd0, m_dz});
      chk("Q", Q, m_q);
      chk("R", R, m_r);
    end
  end

  task automatic do_start(input logic [31:0] a, input logic [31:0] b, input logic s);
    start = 1'b1; A = a; B = b; sign = s;
    @(posedge clk); #1;
    start = 1'b0; A = $urandom; B = $urandom; sign = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_done(input string name, input int exp_n, input int exp_busy);
    int n = 0;
    int bc = 0;
    while (!done && n < 60) begin
      if (busy) bc++;
      @(posedge clk); #1;
      n++;
    end
    chk({name, "_latency"}, n, exp_n);
    chk({name, "_busy_cycles"}, bc, exp_busy);
  endtask

  task automatic run_case(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic s, input logic [31:0] eq, input logic [31:0] er,
                          input logic edz);
    do_start(a, b, s);
    if (b == 32'd0) wait_done(name, 0, 0);
    else            wait_done(name, 33, 33);
    chk({name, "_Q"}, Q, eq);
    chk({name, "_R"}, R, er);
    chk({name, "_dz"}, {31'd0, div_zero}, {31'd0, edz});
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic        rs;
    rst_n = 1'b0; start = 1'b0; sign = 1'b0; A = '0; B = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_Q", Q, 32'd0);
    chk("rst_R", R, 32'd0);
    chk("rst_flags", {29'd0, busy, done, div_zero}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_case("u100_7",   32'd100,        32'd7,          1'b0, 32'd14,         32'd2,          1'b0);
    run_case("s_m7_2",   32'hFFFF_FFF9,  32'd2,          1'b1, 32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0);
    run_case("u_m7_2",   32'hFFFF_FFF9,  32'd2,          1'b0, 32'h7FFF_FFFC,  32'd1,          1'b0);
    run_case("dz_u",     32'h1234_5678,  32'd0,          1'b0, 32'hFFFF_FFFF,  32'h1234_5678,  1'b1);
    run_case("dz_s",     32'h1234_5678,  32'd0,          1'b1, 32'hFFFF_FFFF,  32'h1234_5678,  1'b1);
    run_case("s_ovf",    32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 32'h8000_0000,  32'd0,          1'b0);
    run_case("u_max_1",  32'hFFFF_FFFF,  32'd1,          1'b0, 32'hFFFF_FFFF,  32'd0,          1'b0);
    run_case("s_7_m2",   32'd7,          32'hFFFF_FFFE,  1'b1, 32'hFFFF_FFFD,  32'd1,          1'b0);

    // start mid-division is ignored; start in the done cycle is accepted
    do_start(32'd1000, 32'd9, 1'b0);
    repeat (10) begin @(posedge clk); #1; end
    do_start(32'd55, 32'd5, 1'b0);
    wait_done("ignored", 22, 22);
    chk("ignored_Q", Q, 32'd111);
    chk("ignored_R", R, 32'd1);
    do_start(32'd77, 32'd8, 1'b0);
    wait_done("b2b", 33, 33);
    chk("b2b_Q", Q, 32'd9);
    chk("b2b_R", R, 32'd5);
    @(posedge clk); #1;

    // asynchronous reset mid-division
    do_start(32'hDEAD_BEEF, 32'd3, 1'b0);
    repeat (20) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    chk("arst_Q", Q, 32'd0);
    chk("arst_R", R, 32'd0);
    chk("arst_flags", {29'd0, busy, done, div_zero}, 32'd0);
    @(posedge clk); #3 rst_n = 1'b1;
    @(posedge clk); #1;
    run_case("after_rst", 32'd50, 32'd5, 1'b0, 32'd10, 32'd0, 1'b0);

    for (int i = 0; i < 150; i++) begin
      ra = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = 32'd0;
        1:       rb = $urandom_range(1, 15);
        2:       rb = $urandom;
        default: rb = ($urandom_range(0, 1) != 0) ? 32'hFFFF_FFFF : 32'd1;
      endcase
      if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
      rs = 1'($urandom_range(0, 1));
      do_start(ra, rb, rs);
      if (rb == 32'd0) wait_done("rnd", 0, 0);
      else begin
        wait_done("rnd", 33, 33);
        chk("rnd_identity", Q * rb + R, ra);
      end
      if ($urandom_range(0, 1) != 0) begin
        repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
      end
    end

    repeat (3) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
